uart_tx_fifo: RTL and testbench

Memory-mapped, FIFO-buffered UART transmitter that sits on the CPU data bus beside the data memory and peripheral blocks. It consumes core store cycles and drains queued bytes onto the serial line as 8N1 frames, so software can issue bursts of byte writes without polling per byte. Read data is OR-combined with the other bus slaves and the interrupt output is OR-combined into the core IRQ line.

---
 rtl/uart_tx_pkg.sv | 38 +++
 rtl/uart_tx_fifo_if.sv | 27 ++
 rtl/sync_fifo.sv | 72 +++++++
 rtl/uart_tx_fifo.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and register map for the FIFO-buffered UART transmitter.
// Holds the frame FSM state encoding and the STATUS bit layout.
package uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam logic [31:0] TXDATA_OFS = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

    localparam int unsigned ST_EMPTY_BIT = 0;
    localparam int unsigned ST_FULL_BIT  = 1;
    localparam int unsigned ST_COUNT_LSB = 2;
    localparam int unsigned ST_BUSY_BIT  = 6;
    localparam int unsigned ST_OVF_BIT   = 7;

    function automatic logic [7:0] pack_status(
        input logic       ovf,
        input logic       busy,
        input logic [3:0] count,
        input logic       full,
        input logic       empty
    );
        logic [7:0] s;
        s                      = '0;
        s[ST_OVF_BIT]          = ovf;
        s[ST_BUSY_BIT]         = busy;
        s[ST_COUNT_LSB +: 4]   = count;
        s[ST_FULL_BIT]         = full;
        s[ST_EMPTY_BIT]        = empty;
        return s;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// CPU data-bus slave port: read/write strobes, byte address, write and read data.
// The core side drives through master; peripheral blocks attach as slave.
interface uart_tx_fifo_if;

    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output rd,
        output wr,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  rd,
        input  wr,
        input  addr,
        input  wdata,
        output rdata
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; rdata_o presents the head entry while not empty.
// A push into a full FIFO is accepted when a pop happens on the same edge.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only pointers and count define contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Memory-mapped 8N1 UART transmitter fed by a byte FIFO: TXDATA write pushes,
// STATUS read reports queue state and clears the sticky overflow flag.
module uart_tx_fifo
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned BAUD      = 9600,
    parameter int unsigned DEPTH     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0030
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_fifo_if.slave bus,
    output logic          UART_TX,
    output logic          TX_IRQ
);

    localparam int unsigned DIV    = CLK_HZ / BAUD;
    localparam int unsigned CW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam int unsigned FIFO_CW = $clog2(DEPTH) + 1;

    tx_state_e           state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          bit_q, bit_d;
    logic [7:0]          shift_q, shift_d;
    logic                irq_q, irq_d;
    logic                ovf_q, ovf_d;

    logic                baud_tick;
    logic                pop;
    logic                busy;
    logic                wr_txdata;
    logic                rd_status;

    logic [7:0]          fifo_rdata;
    logic                fifo_full;
    logic                fifo_empty;
    logic [FIFO_CW-1:0]  fifo_count;

    logic                unused_wdata_hi;

    assign unused_wdata_hi = ^bus.wdata[31:8];

    assign wr_txdata = bus.wr && (bus.addr == BASE_ADDR + TXDATA_OFS);
    assign rd_status = bus.rd && (bus.addr == BASE_ADDR + STATUS_OFS);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (wr_txdata),
        .pop_i   (pop),
        .wdata_i (bus.wdata[7:0]),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign baud_tick = (cnt_q == CNT_LAST);

    // State register together with the per-frame datapath it sequences.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            irq_q   <= irq_d;
        end
    end

    // Baud count defaults to zero so every state entry restarts the bit period.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        bit_d   = bit_q;
        shift_d = shift_q;
        irq_d   = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    state_d = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rdata;
                        state_d = START;
                    end else begin
                        irq_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q != IDLE);
        TX_IRQ = irq_q;
        unique case (state_q)
            START:   UART_TX = 1'b0;
            DATA:    UART_TX = shift_q[0];
            default: UART_TX = 1'b1;
        endcase
    end

    // Overflow set wins over a same-edge STATUS read so no drop goes unreported.
    always_comb begin
        ovf_d = ovf_q;
        if (rd_status) begin
            ovf_d = 1'b0;
        end
        if (wr_txdata && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    always_comb begin
        bus.rdata = '0;
        if (rd_status) begin
            bus.rdata = {24'b0, pack_status(ovf_q, busy, 4'(fifo_count),
                                            fifo_full, fifo_empty)};
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at DIV=4, DEPTH=8: frame timing, back-to-back
// frames, overflow/FULL behaviour, same-edge push/pop and asynchronous reset.
module tb_uart_tx_fifo;

    localparam logic [31:0] BASE   = 32'h4000_0030;
    localparam logic [31:0] STATUS = BASE + 32'h4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic UART_TX;
    logic TX_IRQ;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned cyc      = 0;
    int unsigned irq_cnt  = 0;

    uart_tx_fifo_if bus ();

    uart_tx_fifo #(
        .CLK_HZ    (4),
        .BAUD      (1),
        .DEPTH     (8),
        .BASE_ADDR (BASE)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .UART_TX (UART_TX),
        .TX_IRQ  (TX_IRQ)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (TX_IRQ === 1'b1) irq_cnt <= irq_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        bus.wr    = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        step(1);
        bus.wr    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
    endtask

    task automatic bus_rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus.rd   = 1'b1;
        bus.addr = a;
        #1;
        chk(tag, bus.rdata, exp);
        step(1);
        bus.rd   = 1'b0;
        bus.addr = '0;
    endtask

    task automatic rx_chk(input string tag, input logic [7:0] exp);
        int unsigned n;
        logic [7:0]  b;
        n = 0;
        while (UART_TX !== 1'b0 && n < 400) begin
            step(1);
            n++;
        end
        if (UART_TX !== 1'b0) begin
            chk({tag, "_start_timeout"}, UART_TX, 32'd0);
            return;
        end
        step(2);
        for (int i = 0; i < 8; i++) begin
            step(4);
            b[i] = UART_TX;
        end
        chk(tag, b, exp);
        step(4);
        chk({tag, "_stop"}, UART_TX, 32'd1);
    endtask

    initial begin
        logic [9:0]  frame;
        logic [9:0]  fr3 [3];
        int unsigned n0;
        int unsigned mark;
        logic [7:0]  exp_rx [9];

        bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
        step(3);

        chk("rst_tx", UART_TX, 32'd1);
        chk("rst_irq", TX_IRQ, 32'd0);
        chk("rst_rdata_idle", bus.rdata, 32'd0);
        bus.rd = 1'b1; bus.addr = STATUS; #1;
        chk("rst_status", bus.rdata, 32'h01);
        bus.rd = 1'b0; bus.addr = '0;
        reset = 1'b1;

        // Idle after reset
        mark = irq_cnt;
        for (int c = 0; c < 100; c++) begin
            step(1);
            chk("idle_tx", UART_TX, 32'd1);
        end
        chk("idle_irq", irq_cnt - mark, 32'd0);
        bus_rd_chk("idle_status", STATUS, 32'h01);
        bus_rd_chk("rd_txdata_zero", BASE, 32'd0);
        bus_rd_chk("rd_other_zero", BASE + 32'h8, 32'd0);
        bus_wr(STATUS, 32'h0000_00FF);
        bus_wr(BASE + 32'h10, 32'h0000_0055);
        step(2);
        chk("wr_status_ignored_tx", UART_TX, 32'd1);
        bus_rd_chk("wr_status_ignored", STATUS, 32'h01);

        // Single frame 0xA5, upper write data ignored
        bus_wr(BASE, 32'hFFFF_FFA5);
        chk("a5_c0_tx", UART_TX, 32'd1);
        frame = {1'b1, 8'hA5, 1'b0};
        for (int c = 1; c <= 41; c++) begin
            step(1);
            chk($sformatf("a5_tx_c%0d", c), UART_TX, (c <= 40) ? 32'(frame[(c - 1) / 4]) : 32'd1);
            chk($sformatf("a5_irq_c%0d", c), TX_IRQ, (c == 41) ? 32'd1 : 32'd0);
        end
        step(1);
        chk("a5_irq_one_cycle", TX_IRQ, 32'd0);

        // Three back-to-back frames
        fr3[0] = {1'b1, 8'h11, 1'b0};
        fr3[1] = {1'b1, 8'h22, 1'b0};
        fr3[2] = {1'b1, 8'h33, 1'b0};
        bus_wr(BASE, 32'h11);
        bus_wr(BASE, 32'h22);
        bus_wr(BASE, 32'h33);
        for (int c = 3; c <= 121; c++) begin
            step(1);
            if (c <= 120) begin
                frame = fr3[(c - 1) / 40];
                chk($sformatf("b2b_tx_c%0d", c), UART_TX, 32'(frame[((c - 1) % 40) / 4]));
            end else begin
                chk("b2b_tx_end", UART_TX, 32'd1);
            end
            chk($sformatf("b2b_irq_c%0d", c), TX_IRQ, (c == 121) ? 32'd1 : 32'd0);
        end

        // Overflow: 9 writes with first frame in flight fill exactly 8 entries
        step(3);
        bus_wr(BASE, 32'h01);
        n0 = cyc;
        for (int b = 2; b <= 9; b++) bus_wr(BASE, 32'(b));
        bus_rd_chk("full_no_ovf", STATUS, 32'h62);
        bus_wr(BASE, 32'h0A);
        bus_wr(BASE, 32'h0B);
        bus_rd_chk("ovf_set", STATUS, 32'hE2);
        bus_rd_chk("ovf_cleared", STATUS, 32'h62);
        while (cyc < n0 + 40) step(1);
        chk("same_edge_align", cyc - n0, 32'd40);
        bus_wr(BASE, 32'h0C);
        mark = irq_cnt;
        bus_rd_chk("push_pop_same_edge", STATUS, 32'h62);
        for (int b = 0; b < 8; b++) exp_rx[b] = 8'(b + 2);
        exp_rx[8] = 8'h0C;
        for (int b = 0; b < 9; b++) rx_chk($sformatf("drain_b%0d", b), exp_rx[b]);
        step(3);
        chk("drain_irq_count", irq_cnt - mark, 32'd1);
        bus_rd_chk("drain_status", STATUS, 32'h01);

        // Reset in the middle of a data bit with bytes queued
        bus_wr(BASE, 32'h00);
        bus_wr(BASE, 32'h00);
        bus_wr(BASE, 32'h00);
        step(8);
        chk("pre_reset_tx", UART_TX, 32'd0);
        #1;
        reset = 1'b0;
        #1;
        chk("reset_async_tx", UART_TX, 32'd1);
        chk("reset_async_irq", TX_IRQ, 32'd0);
        step(2);
        reset = 1'b1;
        mark = irq_cnt;
        bus_rd_chk("post_reset_status", STATUS, 32'h01);
        for (int c = 0; c < 60; c++) begin
            step(1);
            chk("post_reset_tx", UART_TX, 32'd1);
        end
        chk("post_reset_irq", irq_cnt - mark, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
